// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory bus between two requesters:
//   m0 - core fetch/load/store
//   m1 - program loader / debug
// One transaction is in flight at a time. The arbiter picks a winner in
// IDLE, presents the access to memory for one ISSUE cycle, waits out the
// memory's fixed read latency (reads only) and returns a one-cycle
// response strobe to the winner in RESP. Every output is a flop.
//
// Parameters
//   ADDR_W         address width
//   DATA_W         data width
//   MEM_LATENCY    cycles from the issue cycle to valid mem_rdata_i (1..15)
//   PRIORITY_MODE  0 = round-robin, 1 = fixed priority (m0 wins ties)
//
// Ports
//   clk            clock, rising edge
//   resetn         synchronous active-low reset
//   mN_req_i       request from requester N; held stable until mN_gnt_o
//   mN_we_i        1 = write, 0 = read
//   mN_addr_i      request address
//   mN_wdata_i     request write data
//   mN_gnt_o       one-cycle pulse, request accepted (ISSUE cycle)
//   mN_rvalid_o    one-cycle pulse, read data valid / write done (RESP)
//   mN_rdata_o     read data, valid with mN_rvalid_o, otherwise held
//   mem_addr_o     memory address, held outside an access
//   mem_wdata_o    memory write data
//   mem_we_o       memory write enable, high only in ISSUE of a write
//   mem_rdata_i    memory read data, valid MEM_LATENCY cycles after ISSUE
//   busy_o         high whenever the arbiter is not IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MEM_LATENCY   = 1,
    parameter int PRIORITY_MODE = 0
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              busy_o
);

    // The latency counter is 4 bits wide, so only 1..15 can be honoured.
    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY=%0d outside 1..15", MEM_LATENCY);
    end

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_ISSUE = 2'd1;
    localparam logic [1:0] STATE_WAIT  = 2'd2;
    localparam logic [1:0] STATE_RESP  = 2'd3;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY);

    // Requester ids: 0 = m0, 1 = m1.
    logic [1:0]        state_q,     state_d;
    logic              last_gnt_q,  last_gnt_d;
    logic              id_q,        id_d;
    logic              we_q,        we_d;
    logic [3:0]        cnt_q,       cnt_d;

    logic              m0_gnt_q,    m0_gnt_d;
    logic              m1_gnt_q,    m1_gnt_d;
    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;
    logic [DATA_W-1:0] m0_rdata_q,  m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q,  m1_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q,    mem_we_d;
    logic              busy_q,      busy_d;

    // m1 wins when it asks alone, or on a tie in round-robin mode when m0
    // held the previous grant. In fixed-priority mode m0 always wins ties.
    logic win_m1;
    always_comb begin
        if (PRIORITY_MODE == 0) begin
            win_m1 = m1_req_i && (!m0_req_i || !last_gnt_q);
        end else begin
            win_m1 = m1_req_i && !m0_req_i;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        id_d        = id_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        m0_gnt_d    = 1'b0;
        m1_gnt_d    = 1'b0;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;

        case (state_q)
            STATE_IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    // Latching straight into the bus flops makes the access
                    // visible on the bus during the ISSUE cycle itself.
                    id_d        = win_m1;
                    last_gnt_d  = win_m1;
                    we_d        = win_m1 ? m1_we_i    : m0_we_i;
                    mem_addr_d  = win_m1 ? m1_addr_i  : m0_addr_i;
                    mem_wdata_d = win_m1 ? m1_wdata_i : m0_wdata_i;
                    mem_we_d    = win_m1 ? m1_we_i    : m0_we_i;
                    m0_gnt_d    = !win_m1;
                    m1_gnt_d    = win_m1;
                    state_d     = STATE_ISSUE;
                end
            end

            STATE_ISSUE: begin
                cnt_d = LAT_INIT;
                if (we_q) begin
                    // A write is complete once mem_we has been seen; the
                    // response goes out next cycle with rdata untouched.
                    m0_rvalid_d = !id_q;
                    m1_rvalid_d = id_q;
                    state_d     = STATE_RESP;
                end else begin
                    state_d = STATE_WAIT;
                end
            end

            STATE_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    // mem_rdata_i is valid in this cycle; capture it into the
                    // winner's output flop so it appears together with rvalid.
                    if (id_q) begin
                        m1_rdata_d  = mem_rdata_i;
                        m1_rvalid_d = 1'b1;
                    end else begin
                        m0_rdata_d  = mem_rdata_i;
                        m0_rvalid_d = 1'b1;
                    end
                    state_d = STATE_RESP;
                end
            end

            STATE_RESP: begin
                state_d = STATE_IDLE;
            end

            default: begin
                state_d = STATE_IDLE;
            end
        endcase

        busy_d = (state_d != STATE_IDLE);
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= STATE_IDLE;
            last_gnt_q  <= 1'b1;          // m0 wins the first tie
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            id_q        <= id_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            m0_gnt_q    <= m0_gnt_d;
            m1_gnt_q    <= m1_gnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
        end
    end

    assign m0_gnt_o    = m0_gnt_q;
    assign m1_gnt_o    = m1_gnt_q;
    assign m0_rvalid_o = m0_rvalid_q;
    assign m1_rvalid_o = m1_rvalid_q;
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Three arbiter instances, each with its own memory model:
//   0: round-robin,    MEM_LATENCY=1
//   1: fixed priority, MEM_LATENCY=1
//   2: round-robin,    MEM_LATENCY=3
// Memory words are indexed by addr[7:2] and reload to init_word() on reset.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [2:0]  m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [2:0]  m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [2:0]  mem_we, busy;
    logic [31:0] m0_addr [3];
    logic [31:0] m0_wdata[3];
    logic [31:0] m0_rdata[3];
    logic [31:0] m1_addr [3];
    logic [31:0] m1_wdata[3];
    logic [31:0] m1_rdata[3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata[3];
    logic [31:0] mem_rdata[3];

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4)       return 32'hDEADBEEF;   // 0x10
        else if (i == 16) return 32'hCAFEF00D;   // 0x40
        else              return 32'h1000_0000 + 32'(i);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 3 : 1;
        localparam int PM  = (g == 1) ? 1 : 0;

        logic [31:0] mem  [64];
        logic [31:0] pipe [LAT];

        always @(posedge clk) begin
            if (!resetn) begin
                for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
                for (int i = 0; i < LAT; i++) pipe[i] <= '0;
            end else begin
                if (mem_we[g]) mem[mem_addr[g][7:2]] <= mem_wdata[g];
                pipe[0] <= mem[mem_addr[g][7:2]];
                for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign mem_rdata[g] = pipe[LAT-1];

        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .PRIORITY_MODE(PM)
        ) u_dut (
            .clk        (clk),
            .resetn     (resetn),
            .m0_req_i   (m0_req[g]),
            .m0_we_i    (m0_we[g]),
            .m0_addr_i  (m0_addr[g]),
            .m0_wdata_i (m0_wdata[g]),
            .m0_gnt_o   (m0_gnt[g]),
            .m0_rvalid_o(m0_rvalid[g]),
            .m0_rdata_o (m0_rdata[g]),
            .m1_req_i   (m1_req[g]),
            .m1_we_i    (m1_we[g]),
            .m1_addr_i  (m1_addr[g]),
            .m1_wdata_i (m1_wdata[g]),
            .m1_gnt_o   (m1_gnt[g]),
            .m1_rvalid_o(m1_rvalid[g]),
            .m1_rdata_o (m1_rdata[g]),
            .mem_addr_o (mem_addr[g]),
            .mem_wdata_o(mem_wdata[g]),
            .mem_we_o   (mem_we[g]),
            .mem_rdata_i(mem_rdata[g]),
            .busy_o     (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a grant; who = 0/1 (2 if both pulse, -1 on timeout),
    // cyc = ticks taken.
    task automatic wait_gnt(input int d, output int who, output int cyc);
        who = -1;
        cyc = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (m0_gnt[d] || m1_gnt[d]) begin
                cyc = k;
                who = (m0_gnt[d] && m1_gnt[d]) ? 2 : (m1_gnt[d] ? 1 : 0);
                break;
            end
        end
    endtask

    task automatic wait_rv(input int d, output int who, output int cyc);
        who = -1;
        cyc = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (m0_rvalid[d] || m1_rvalid[d]) begin
                cyc = k;
                who = (m0_rvalid[d] && m1_rvalid[d]) ? 2 : (m1_rvalid[d] ? 1 : 0);
                break;
            end
        end
    endtask

    initial begin
        int who;
        int cyc;

        resetn = 1'b0;
        m0_req = '0; m0_we = '0; m1_req = '0; m1_we = '0;
        for (int i = 0; i < 3; i++) begin
            m0_addr[i] = '0; m0_wdata[i] = '0;
            m1_addr[i] = '0; m1_wdata[i] = '0;
        end
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // Reset state
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_gnt",      32'({m0_gnt, m1_gnt}), 32'd0);
        check("rst_rvalid",   32'({m0_rvalid, m1_rvalid}), 32'd0);
        check("rst_mem_we",   32'(mem_we),    32'd0);
        check("rst_mem_addr", mem_addr[0],    32'd0);
        check("rst_m0_rdata", m0_rdata[0],    32'd0);

        // 1: m0 read 0x10 -> 0xDEADBEEF, gnt cycle 1, rvalid cycle 3
        m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_addr[0] = 32'h10;
        wait_gnt(0, who, cyc);
        check("t1_gnt_who",   32'(who), 32'd0);
        check("t1_gnt_cycle", 32'(cyc), 32'd1);
        check("t1_mem_addr",  mem_addr[0], 32'h10);
        check("t1_mem_we",    32'(mem_we[0]), 32'd0);
        check("t1_busy",      32'(busy[0]), 32'd1);
        m0_req[0] = 1'b0;
        wait_rv(0, who, cyc);
        check("t1_rv_who",    32'(who), 32'd0);
        check("t1_rv_cycle",  32'(cyc), 32'd2);
        check("t1_rdata",     m0_rdata[0], 32'hDEADBEEF);
        check("t1_m1_rdata",  m1_rdata[0], 32'd0);
        tick();
        check("t1_rv_off",    32'(m0_rvalid[0]), 32'd0);
        check("t1_idle",      32'(busy[0]), 32'd0);

        // 2: m1 write 0x20 <- 0x1234
        m1_req[0] = 1'b1; m1_we[0] = 1'b1; m1_addr[0] = 32'h20; m1_wdata[0] = 32'h1234;
        wait_gnt(0, who, cyc);
        check("t2_gnt_who",   32'(who), 32'd1);
        check("t2_mem_we",    32'(mem_we[0]), 32'd1);
        check("t2_mem_addr",  mem_addr[0], 32'h20);
        check("t2_mem_wdata", mem_wdata[0], 32'h1234);
        m1_req[0] = 1'b0;
        tick();
        check("t2_mem_we_off", 32'(mem_we[0]), 32'd0);
        check("t2_rvalid",     32'(m1_rvalid[0]), 32'd1);
        check("t2_m0_rvalid",  32'(m0_rvalid[0]), 32'd0);
        check("t2_rdata_held", m1_rdata[0], 32'd0);
        check("t2_mem_addr_hold", mem_addr[0], 32'h20);
        tick();
        check("t2_rv_off",    32'(m1_rvalid[0]), 32'd0);
        check("t2_mem_word",  g_dut[0].mem[8], 32'h1234);
        m1_req[0] = 1'b1; m1_we[0] = 1'b0;
        wait_gnt(0, who, cyc);
        check("t2_rb_gnt",    32'(who), 32'd1);
        m1_req[0] = 1'b0;
        wait_rv(0, who, cyc);
        check("t2_rb_who",    32'(who), 32'd1);
        check("t2_rb_data",   m1_rdata[0], 32'h1234);

        // 3: round-robin with both requesters held
        m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_addr[0] = 32'h14;
        m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 32'h18;
        for (int t = 0; t < 4; t++) begin
            wait_gnt(0, who, cyc);
            check($sformatf("t3_gnt%0d", t), 32'(who), 32'(t % 2));
            wait_rv(0, who, cyc);
            check($sformatf("t3_rv%0d", t), 32'(who), 32'(t % 2));
            if (t % 2 == 0) begin
                check($sformatf("t3_m0_data%0d", t), m0_rdata[0], 32'h1000_0005);
            end else begin
                check($sformatf("t3_m1_data%0d", t), m1_rdata[0], 32'h1000_0006);
                check($sformatf("t3_m0_hold%0d", t), m0_rdata[0], 32'h1000_0005);
            end
            if (t == 3) begin
                m0_req[0] = 1'b0;
                m1_req[0] = 1'b0;
            end
        end
        tick();

        // 4: fixed priority, m1 starves until m0 drops
        m0_req[1] = 1'b1; m0_we[1] = 1'b0; m0_addr[1] = 32'h10;
        m1_req[1] = 1'b1; m1_we[1] = 1'b0; m1_addr[1] = 32'h18;
        for (int t = 0; t < 3; t++) begin
            wait_gnt(1, who, cyc);
            check($sformatf("t4_gnt%0d", t), 32'(who), 32'd0);
            if (t == 2) m0_req[1] = 1'b0;
            wait_rv(1, who, cyc);
            check($sformatf("t4_rv%0d", t), 32'(who), 32'd0);
            check($sformatf("t4_data%0d", t), m0_rdata[1], 32'hDEADBEEF);
        end
        wait_gnt(1, who, cyc);
        check("t4_m1_gnt",  32'(who), 32'd1);
        m1_req[1] = 1'b0;
        wait_rv(1, who, cyc);
        check("t4_m1_rv",   32'(who), 32'd1);
        check("t4_m1_data", m1_rdata[1], 32'h1000_0006);

        // 5: MEM_LATENCY=3, rvalid exactly 4 cycles after gnt
        m0_req[2] = 1'b1; m0_we[2] = 1'b0; m0_addr[2] = 32'h40;
        wait_gnt(2, who, cyc);
        check("t5_gnt_who", 32'(who), 32'd0);
        check("t5_busy0",   32'(busy[2]), 32'd1);
        m0_req[2] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("t5_rvalid%0d", k), 32'(m0_rvalid[2]), 32'(k == 4));
            check($sformatf("t5_busy%0d", k),   32'(busy[2]),      32'(k <= 4));
            check($sformatf("t5_we%0d", k),     32'(mem_we[2]),    32'd0);
            if (k == 4) check("t5_data", m0_rdata[2], 32'hCAFEF00D);
        end

        // 6: reset during WAIT aborts, then m1 read served normally
        m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_addr[0] = 32'h10;
        wait_gnt(0, who, cyc);
        check("t6_gnt_who", 32'(who), 32'd0);
        m0_req[0] = 1'b0;
        tick();
        check("t6_wait_busy", 32'(busy[0]), 32'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("t6_rvalid",   32'({m0_rvalid[0], m1_rvalid[0]}), 32'd0);
        check("t6_m0_rdata", m0_rdata[0], 32'd0);
        check("t6_m1_rdata", m1_rdata[0], 32'd0);
        check("t6_mem_addr", mem_addr[0], 32'd0);
        check("t6_mem_we",   32'(mem_we[0]), 32'd0);
        check("t6_busy",     32'(busy[0]), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("t6_no_rv%0d", k), 32'({m0_rvalid[0], busy[0]}), 32'd0);
        end
        m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 32'h18;
        wait_gnt(0, who, cyc);
        check("t6_m1_gnt",   32'(who), 32'd1);
        check("t6_m1_cycle", 32'(cyc), 32'd1);
        m1_req[0] = 1'b0;
        wait_rv(0, who, cyc);
        check("t6_m1_rv",    32'(who), 32'd1);
        check("t6_m1_rvcyc", 32'(cyc), 32'd2);
        check("t6_m1_data",  m1_rdata[0], 32'h1000_0006);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
